axi_req_arbiter: RTL and testbench

//   Front end of the AXI bridge. Takes an instruction port (read-only, SRAM-like) and a data port (read/write, SRAM-like).

---
 rtl/axi_req_arbiter.sv | 130 +++++++++++++
 tb/tb_axi_req_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: AXI bridge front end; inst/data reads share AR, data writes launch to a write engine; optional `ARB_ROUND_ROBIN_EN selects round-robin read arbitration
module axi_req_arbiter #(
  parameter logic [3:0] INST_ARID = 4'd0,
  parameter logic [3:0] DATA_ARID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_strb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [1:0]  wr_size,
  output logic [3:0]  wr_strb,
  output logic [31:0] wr_data,
  input  logic        wr_addr_ok,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
  typedef enum logic {W_IDLE, W_WAIT_B} w_state_t;
  ar_state_t   ar_q, ar_d;
  w_state_t    w_q, w_d;
  logic        inst_pend_q, inst_pend_d;
  logic        data_pend_q, data_pend_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        inst_cand, data_cand, inst_gnt, data_gnt;
  logic        wr_acc, inst_ret, data_rret, data_bret;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_data_q, last_data_d;
`endif
  // Grant, accept and return decisions; all suppressed while reset is held
  always_comb begin
    inst_cand = !reset && ar_q == AR_IDLE && inst_req && !inst_pend_q;
    data_cand = !reset && ar_q == AR_IDLE && data_req && !data_wr && !data_pend_q;
`ifdef ARB_ROUND_ROBIN_EN
    data_gnt  = data_cand && (!inst_cand || !last_data_q);
`else
    data_gnt  = data_cand;
`endif
    inst_gnt  = inst_cand && !data_gnt;
    wr_acc    = !reset && data_req && data_wr && !data_pend_q && w_q == W_IDLE && wr_addr_ok;
    inst_ret  = !reset && rvalid && rid == INST_ARID && inst_pend_q;
    data_rret = !reset && rvalid && rid == DATA_ARID && data_pend_q && w_q == W_IDLE;
    data_bret = !reset && bvalid && w_q == W_WAIT_B;
  end
  // Next state: FSMs, latched AR payload and per-port pending flags (new accept beats a return)
  always_comb begin
    ar_d = ar_q;
    if (ar_q == AR_BUSY && arready) ar_d = AR_IDLE;
    if (inst_gnt || data_gnt) ar_d = AR_BUSY;
    w_d = w_q;
    if (wr_acc) w_d = W_WAIT_B;
    if (data_bret) w_d = W_IDLE;
    arid_d      = data_gnt ? DATA_ARID : inst_gnt ? INST_ARID : arid_q;
    araddr_d    = data_gnt ? data_addr : inst_gnt ? inst_addr : araddr_q;
    arsize_d    = data_gnt ? {1'b0, data_size} : inst_gnt ? {1'b0, inst_size} : arsize_q;
    inst_pend_d = inst_gnt ? 1'b1 : inst_ret ? 1'b0 : inst_pend_q;
    data_pend_d = (data_gnt || wr_acc) ? 1'b1 : (data_rret || data_bret) ? 1'b0 : data_pend_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d = data_gnt ? 1'b1 : inst_gnt ? 1'b0 : last_data_q;
`endif
  end
  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q        <= AR_IDLE;
      w_q         <= W_IDLE;
      inst_pend_q <= 1'b0;
      data_pend_q <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arsize_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      ar_q        <= ar_d;
      w_q         <= w_d;
      inst_pend_q <= inst_pend_d;
      data_pend_q <= data_pend_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end
  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt || wr_acc;
  assign inst_data_ok = inst_ret;
  assign data_data_ok = data_rret || data_bret;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign arvalid      = ar_q == AR_BUSY;
  assign arid         = arid_q;
  assign araddr       = araddr_q;
  assign arsize       = arsize_q;
  assign rready       = 1'b1;
  assign bready       = 1'b1;
  assign wr_req       = wr_acc;
  assign wr_addr      = data_addr;
  assign wr_size      = data_size;
  assign wr_strb      = data_strb;
  assign wr_data      = data_wdata;
endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb_axi_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_axi_req_arbiter;
  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [1:0]  inst_size;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_strb;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize;
  logic        arvalid, arready, rvalid, rready;
  logic        wr_req, wr_addr_ok, bvalid, bready;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  wr_size;
  logic [3:0]  wr_strb;
  logic [5:0]  flags;
  int n_checks = 0;
  int n_fail = 0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  assign flags = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, wr_req};

  axi_req_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_size(data_size),
    .data_strb(data_strb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb), .wr_data(wr_data),
    .wr_addr_ok(wr_addr_ok), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    inst_req = 0; inst_addr = 0; inst_size = 0;
    data_req = 0; data_wr = 0; data_addr = 0; data_size = 0; data_strb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; wr_addr_ok = 0; bvalid = 0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1;
    nxt(); nxt();
    reset = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; inst_req = 1; data_req = 1; data_wr = 1; wr_addr_ok = 1;
    rvalid = 1; bvalid = 1; arready = 1;
    nxt(); smp();
    n_checks++; if (flags !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp %b", flags, 6'b0); end
    n_checks++; if ({arid, araddr, arsize} !== 39'h0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", {arid, araddr, arsize}); end
    n_checks++; if ({rready, bready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b exp 11", {rready, bready}); end
    nxt();
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_single_read;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2;
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t1_grant got %b exp %b", flags, 6'b100000); end
    nxt();
    inst_req = 0;
    for (int c = 1; c <= 4; c++) begin
      arready = (c == 4);
      smp();
      n_checks++; if (flags !== 6'b000010) begin n_fail++; $display("FAIL t1_arvalid c%0d got %b exp %b", c, flags, 6'b000010); end
      n_checks++; if ({arid, araddr, arsize} !== {4'd0, 32'h1C00_0000, 3'd2}) begin n_fail++; $display("FAIL t1_ar_payload c%0d got %h exp %h", c, {arid, araddr, arsize}, {4'd0, 32'h1C00_0000, 3'd2}); end
      nxt();
    end
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h1234_5678;
    smp();
    n_checks++; if (flags !== 6'b001000) begin n_fail++; $display("FAIL t1_return got %b exp %b", flags, 6'b001000); end
    n_checks++; if (inst_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL t1_rdata got %h exp 12345678", inst_rdata); end
    nxt();
    smp();
    n_checks++; if (flags !== 6'b0) begin n_fail++; $display("FAIL t1_stray_r got %b exp %b", flags, 6'b0); end
    nxt();
    rvalid = 0;
  endtask

  task automatic test_conflict;
    apply_reset();
    arready = 1;
    inst_req = 1; inst_addr = 32'h1C00_0040; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h800; data_size = 2;
    smp();
    n_checks++; if (flags !== 6'b010000) begin n_fail++; $display("FAIL t2_first got %b exp %b", flags, 6'b010000); end
    nxt();
    data_req = 0;
    smp();
    n_checks++; if ({flags, arid, araddr} !== {6'b000010, 4'd1, 32'h800}) begin n_fail++; $display("FAIL t2_busy got %h exp %h", {flags, arid, araddr}, {6'b000010, 4'd1, 32'h800}); end
    nxt();
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t2_inst_after got %b exp %b", flags, 6'b100000); end
    nxt();
    inst_req = 0;
    smp();
    n_checks++; if ({flags, arid, araddr} !== {6'b000010, 4'd0, 32'h1C00_0040}) begin n_fail++; $display("FAIL t2_busy2 got %h exp %h", {flags, arid, araddr}, {6'b000010, 4'd0, 32'h1C00_0040}); end
    nxt();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_1111;
    smp();
    n_checks++; if (flags !== 6'b001000) begin n_fail++; $display("FAIL t2_ret_inst got %b exp %b", flags, 6'b001000); end
    nxt();
    rid = 1; rdata = 32'h0000_2222;
    smp();
    n_checks++; if ({flags, data_rdata} !== {6'b000100, 32'h0000_2222}) begin n_fail++; $display("FAIL t2_ret_data got %h exp %h", {flags, data_rdata}, {6'b000100, 32'h0000_2222}); end
    nxt();
    rvalid = 0; arready = 1;
    data_req = 1; data_addr = 32'h900;
    smp();
    n_checks++; if (flags !== 6'b010000) begin n_fail++; $display("FAIL t2_lone_data got %b exp %b", flags, 6'b010000); end
    nxt();
    data_req = 0;
    nxt();
    rvalid = 1; rid = 1; rdata = 32'h0000_3333;
    smp();
    n_checks++; if (flags !== 6'b000100) begin n_fail++; $display("FAIL t2_lone_ret got %b exp %b", flags, 6'b000100); end
    nxt();
    rvalid = 0;
    inst_req = 1; data_req = 1; data_addr = 32'h804;
    smp();
    n_checks++; if (flags !== (RR ? 6'b100000 : 6'b010000)) begin n_fail++; $display("FAIL t2_repeat got %b exp %b", flags, RR ? 6'b100000 : 6'b010000); end
    nxt();
    smp();
    n_checks++; if ({flags, arid} !== {6'b000010, RR ? 4'd0 : 4'd1}) begin n_fail++; $display("FAIL t2_repeat_busy got %h exp %h", {flags, arid}, {6'b000010, RR ? 4'd0 : 4'd1}); end
    nxt();
    smp();
    n_checks++; if (flags !== (RR ? 6'b010000 : 6'b100000)) begin n_fail++; $display("FAIL t2_repeat_second got %b exp %b", flags, RR ? 6'b010000 : 6'b100000); end
    nxt();
    inst_req = 0; data_req = 0;
    nxt();
    rvalid = 1; rid = 0;
    smp();
    n_checks++; if (flags !== 6'b001000) begin n_fail++; $display("FAIL t2_drain_inst got %b exp %b", flags, 6'b001000); end
    nxt();
    rid = 1;
    smp();
    n_checks++; if (flags !== 6'b000100) begin n_fail++; $display("FAIL t2_drain_data got %b exp %b", flags, 6'b000100); end
    nxt();
    rvalid = 0;
  endtask

  task automatic test_write;
    apply_reset();
    data_req = 1; data_wr = 1; data_addr = 32'h800; data_size = 2;
    data_strb = 4'b0011; data_wdata = 32'hAABB_CCDD; wr_addr_ok = 0;
    smp();
    n_checks++; if (flags !== 6'b0) begin n_fail++; $display("FAIL t3_engine_busy got %b exp %b", flags, 6'b0); end
    nxt();
    wr_addr_ok = 1;
    smp();
    n_checks++; if (flags !== 6'b010001) begin n_fail++; $display("FAIL t3_accept got %b exp %b", flags, 6'b010001); end
    n_checks++; if ({wr_addr, wr_size, wr_strb, wr_data} !== {32'h800, 2'd2, 4'b0011, 32'hAABB_CCDD}) begin n_fail++; $display("FAIL t3_payload got %h exp %h", {wr_addr, wr_size, wr_strb, wr_data}, {32'h800, 2'd2, 4'b0011, 32'hAABB_CCDD}); end
    nxt();
    data_wdata = 32'h1122_3344;
    smp();
    n_checks++; if (flags !== 6'b0) begin n_fail++; $display("FAIL t3_stall got %b exp %b", flags, 6'b0); end
    nxt();
    data_wr = 0; inst_req = 1; inst_addr = 32'h1C00_0080;
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t3_read_stall got %b exp %b", flags, 6'b100000); end
    nxt();
    inst_req = 0; data_wr = 1; bvalid = 1;
    smp();
    n_checks++; if (flags !== 6'b000110) begin n_fail++; $display("FAIL t3_bresp got %b exp %b", flags, 6'b000110); end
    nxt();
    bvalid = 0;
    smp();
    n_checks++; if ({flags, wr_data} !== {6'b010011, 32'h1122_3344}) begin n_fail++; $display("FAIL t3_second got %h exp %h", {flags, wr_data}, {6'b010011, 32'h1122_3344}); end
    nxt();
    data_req = 0; bvalid = 1; arready = 1;
    smp();
    n_checks++; if (flags !== 6'b000110) begin n_fail++; $display("FAIL t3_bresp2 got %b exp %b", flags, 6'b000110); end
    nxt();
    bvalid = 0; arready = 0; rvalid = 1; rid = 0;
    smp();
    n_checks++; if (flags !== 6'b001000) begin n_fail++; $display("FAIL t3_inst_ret got %b exp %b", flags, 6'b001000); end
    nxt();
    rvalid = 0;
  endtask

  task automatic test_out_of_order;
    apply_reset();
    arready = 1;
    inst_req = 1; inst_addr = 32'h100; inst_size = 2;
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t4_inst got %b exp %b", flags, 6'b100000); end
    nxt();
    inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h200; data_size = 1;
    smp();
    n_checks++; if (flags !== 6'b000010) begin n_fail++; $display("FAIL t4_busy got %b exp %b", flags, 6'b000010); end
    nxt();
    smp();
    n_checks++; if (flags !== 6'b010000) begin n_fail++; $display("FAIL t4_data got %b exp %b", flags, 6'b010000); end
    nxt();
    data_req = 0;
    smp();
    n_checks++; if ({flags, arid, araddr, arsize} !== {6'b000010, 4'd1, 32'h200, 3'd1}) begin n_fail++; $display("FAIL t4_ar got %h exp %h", {flags, arid, araddr, arsize}, {6'b000010, 4'd1, 32'h200, 3'd1}); end
    nxt();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'hCAFE_0001;
    smp();
    n_checks++; if ({flags, data_rdata} !== {6'b000100, 32'hCAFE_0001}) begin n_fail++; $display("FAIL t4_data_first got %h exp %h", {flags, data_rdata}, {6'b000100, 32'hCAFE_0001}); end
    nxt();
    rid = 0; rdata = 32'hCAFE_0000;
    smp();
    n_checks++; if ({flags, inst_rdata} !== {6'b001000, 32'hCAFE_0000}) begin n_fail++; $display("FAIL t4_inst_second got %h exp %h", {flags, inst_rdata}, {6'b001000, 32'hCAFE_0000}); end
    nxt();
    rvalid = 0;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2;
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t5_grant got %b exp %b", flags, 6'b100000); end
    nxt();
    inst_req = 0;
    nxt();
    reset = 1; data_req = 1; data_wr = 1; wr_addr_ok = 1;
    smp();
    n_checks++; if (flags !== 6'b000010) begin n_fail++; $display("FAIL t5_in_reset got %b exp %b", flags, 6'b000010); end
    nxt();
    reset = 0; data_req = 0; rvalid = 1; rid = 0; bvalid = 1; inst_req = 1;
    smp();
    n_checks++; if (flags !== 6'b100000) begin n_fail++; $display("FAIL t5_after got %b exp %b", flags, 6'b100000); end
    nxt();
    idle_inputs();
    apply_reset();
  endtask

  task automatic test_random;
    bit m_ip, m_dr, m_dw, m_busy, m_last_data;
    logic [38:0] m_ar;
    bit ic, dc, ig, dg, wa, ir, drr, br;
    logic [5:0] exp_flags;
    apply_reset();
    m_ip = 0; m_dr = 0; m_dw = 0; m_busy = 0; m_last_data = 0; m_ar = '0;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      inst_req   = 1'($urandom_range(0, 1));
      inst_addr  = $urandom;
      inst_size  = 2'($urandom_range(0, 3));
      data_req   = 1'($urandom_range(0, 1));
      data_wr    = 1'($urandom_range(0, 1));
      data_addr  = $urandom;
      data_size  = 2'($urandom_range(0, 3));
      data_strb  = 4'($urandom_range(0, 15));
      data_wdata = $urandom;
      arready    = 1'($urandom_range(0, 1));
      wr_addr_ok = ($urandom_range(0, 3) != 0);
      rvalid     = ($urandom_range(0, 2) == 0);
      rid        = m_dw ? ($urandom_range(0, 1) ? 4'd0 : 4'd2) : 4'($urandom_range(0, 2));
      rdata      = $urandom;
      bvalid     = ($urandom_range(0, 2) == 0);
      ig = 0; dg = 0; wa = 0; ir = 0; drr = 0; br = 0;
      if (!reset) begin
        ic = !m_busy && inst_req && !m_ip;
        dc = !m_busy && data_req && !data_wr && !(m_dr || m_dw);
        if (ic && dc) begin
          dg = RR ? !m_last_data : 1'b1;
          ig = !dg;
        end else begin
          ig = ic;
          dg = dc;
        end
        wa  = data_req && data_wr && !(m_dr || m_dw) && wr_addr_ok;
        ir  = rvalid && rid == 4'd0 && m_ip;
        drr = rvalid && rid == 4'd1 && m_dr;
        br  = bvalid && m_dw;
      end
      exp_flags = {ig, dg || wa, ir, drr || br, m_busy, wa};
      smp();
      n_checks++; if (flags !== exp_flags) begin n_fail++; $display("FAIL rnd_flags cyc %0d got %b exp %b", i, flags, exp_flags); end
      if (m_busy) begin
        n_checks++; if ({arid, araddr, arsize} !== m_ar) begin n_fail++; $display("FAIL rnd_ar cyc %0d got %h exp %h", i, {arid, araddr, arsize}, m_ar); end
      end
      if (wa) begin
        n_checks++; if ({wr_addr, wr_size, wr_strb, wr_data} !== {data_addr, data_size, data_strb, data_wdata}) begin n_fail++; $display("FAIL rnd_wr cyc %0d got %h exp %h", i, {wr_addr, wr_size, wr_strb, wr_data}, {data_addr, data_size, data_strb, data_wdata}); end
      end
      if (ir) begin
        n_checks++; if (inst_rdata !== rdata) begin n_fail++; $display("FAIL rnd_irdata cyc %0d got %h exp %h", i, inst_rdata, rdata); end
      end
      if (drr) begin
        n_checks++; if (data_rdata !== rdata) begin n_fail++; $display("FAIL rnd_drdata cyc %0d got %h exp %h", i, data_rdata, rdata); end
      end
      if (reset) begin
        m_ip = 0; m_dr = 0; m_dw = 0; m_busy = 0; m_last_data = 0; m_ar = '0;
      end else begin
        if (m_busy && arready) m_busy = 0;
        if (ir) m_ip = 0;
        if (drr) m_dr = 0;
        if (br) m_dw = 0;
        if (ig) begin m_busy = 1; m_ip = 1; m_last_data = 0; m_ar = {4'd0, inst_addr, 1'b0, inst_size}; end
        if (dg) begin m_busy = 1; m_dr = 1; m_last_data = 1; m_ar = {4'd1, data_addr, 1'b0, data_size}; end
        if (wa) m_dw = 1;
      end
      nxt();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    nxt();
    test_reset();
    test_single_read();
    test_conflict();
    test_write();
    test_out_of_order();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
